wb_rr_arbiter2: RTL

Two-master, one-slave Wishbone arbiter that lets an instruction port (M0) and a data port (M1) share a single memory/controller bus. Requests are granted round-robin. The winning request is registered onto the slave bus and the slave response is returned registered, which matches the pipelined-Wishbone response timing the processor wrappers already use. A per-transaction timeout turns a missing `s_ack` into an error pulse so that a stalled slave cannot hang the core.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/wb_rr_arbiter2.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
// The latched request record is sized by the package widths below.
package wb_arb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;

  typedef logic arb_gnt_t;
  localparam arb_gnt_t GNT_M0 = 1'b0;
  localparam arb_gnt_t GNT_M1 = 1'b1;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the master that was not
// granted last wins; a lone request always wins.
module rr_arb2
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_gnt_t   last_grant,
  output arb_gnt_t   grant
);

  always_comb begin
    grant = GNT_M0;
    if (req == 2'b11) begin
      grant = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (req == 2'b10) begin
      grant = GNT_M1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with registered request/response
// paths and a per-transaction ack timeout that turns a stall into an error.
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 255,
  parameter  int ADDR_W         = WB_ADDR_W,
  parameter  int DATA_W         = WB_DATA_W,
  localparam int SEL_W          = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data_out,
  output logic [DATA_W-1:0] m0_data_in,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data_out,
  output logic [DATA_W-1:0] m1_data_in,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [SEL_W-1:0]  s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data_out,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_ack
);

  localparam int               CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  arb_state_t        state_q, state_d;
  arb_gnt_t          grant_q, grant_d;
  arb_gnt_t          lastGrant_q, lastGrant_d;
  arb_gnt_t          rrGrant;
  wb_req_t           req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sStb_q, sStb_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] m0Data_q, m0Data_d;
  logic [DATA_W-1:0] m1Data_q, m1Data_d;
  logic [1:0]        reqPending;
  logic              timeoutHit;

  assign reqPending = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

  rr_arb2 u_rr_arb2 (
    .req        (reqPending),
    .last_grant (lastGrant_q),
    .grant      (rrGrant)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    sStb_d      = sStb_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    m0Data_d    = m0Data_q;
    m1Data_d    = m1Data_q;

    case (state_q)
      ARB_IDLE: begin
        if (|reqPending) begin
          grant_d = rrGrant;
          if (rrGrant == GNT_M1) begin
            req_d.we   = m1_we;
            req_d.sel  = WB_SEL_W'(m1_sel);
            req_d.addr = WB_ADDR_W'(m1_addr);
            req_d.data = WB_DATA_W'(m1_data_out);
          end else begin
            req_d.we   = m0_we;
            req_d.sel  = WB_SEL_W'(m0_sel);
            req_d.addr = WB_ADDR_W'(m0_addr);
            req_d.data = WB_DATA_W'(m0_data_out);
          end
          cnt_d   = '0;
          sStb_d  = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A real ack wins over a timeout that expires in the same cycle.
        if (s_ack) begin
          if (grant_q == GNT_M1) begin
            m1Data_d = s_data_in;
          end else begin
            m0Data_d = s_data_in;
          end
          sStb_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ARB_RESP;
        end else if (timeoutHit) begin
          sStb_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_RESP: begin
        lastGrant_d = grant_q;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= GNT_M0;
      lastGrant_q <= GNT_M1;
      req_q       <= '0;
      cnt_q       <= '0;
      sStb_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      m0Data_q    <= '0;
      m1Data_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      sStb_q      <= sStb_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      m0Data_q    <= m0Data_d;
      m1Data_q    <= m1Data_d;
    end
  end

  assign s_cyc      = sStb_q;
  assign s_stb      = sStb_q;
  assign s_we       = req_q.we;
  assign s_sel      = SEL_W'(req_q.sel);
  assign s_addr     = ADDR_W'(req_q.addr);
  assign s_data_out = DATA_W'(req_q.data);

  assign m0_data_in = m0Data_q;
  assign m1_data_in = m1Data_q;
  assign m0_ack     = ack_q & (grant_q == GNT_M0);
  assign m1_ack     = ack_q & (grant_q == GNT_M1);
  assign m0_err     = err_q & (grant_q == GNT_M0);
  assign m1_err     = err_q & (grant_q == GNT_M1);

endmodule
